// File: rtl/bc_input_port_if.sv
// Byte-stream handshake between the host and the Basic Computer input port.
interface bc_input_port_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bc_input_port.sv
// Basic Computer input device: buffers host characters in a FIFO and presents
// them one at a time in INPR with FGI set until the controller executes INP.
module bc_input_port #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bc_input_port_if.slave         host,
    input  logic                   inp_ack,
    input  logic                   flush,
    output logic                   FGI,
    output logic [DATA_W-1:0]      INPR,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   ack_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCount = DEPTH[PW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // Ready depends only on stored count, so a same-cycle pop never opens a full FIFO.
    assign host.in_ready = (fifo_count != FullCount);
    assign push          = host.in_valid && host.in_ready;
    assign pop           = (fifo_count != '0) && (!FGI || inp_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            FGI        <= 1'b0;
            INPR       <= '0;
            ack_err    <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            FGI        <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= host.in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                INPR   <= mem[rd_ptr];
                FGI    <= 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
            end else if (inp_ack && FGI) begin
                FGI <= 1'b0;
            end
            if (inp_ack && !FGI) begin
                ack_err <= 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bc_input_port.sv
// Directed bench for bc_input_port: each task drives one scenario and checks
// the packed observation {FGI, INPR, fifo_count, in_ready, ack_err}.
module tb_bc_input_port;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       inp_ack;
    logic       flush;
    logic       fgi;
    logic [7:0] inpr;
    logic [2:0] fifo_count;
    logic       ack_err;
    int         total = 0;
    int         bad = 0;

    bc_input_port_if #(.DATA_W(8)) host ();

    bc_input_port #(.DEPTH(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (host),
        .inp_ack    (inp_ack),
        .flush      (flush),
        .FGI        (fgi),
        .INPR       (inpr),
        .fifo_count (fifo_count),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    logic [13:0] obs;
    assign obs = {fgi, inpr, fifo_count, host.in_ready, ack_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        rst_n         = 1'b0;
        inp_ack       = 1'b0;
        flush         = 1'b0;
        host.in_valid = 1'b1;
        host.in_data  = 8'hAA;
        tick();
        tick();
        host.in_valid = 1'b0;
        rst_n         = 1'b1;
        exp = {1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs, exp);
        end
        tick();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_latency();
        logic [13:0] exp;
        host.in_valid = 1'b1;
        host.in_data  = 8'h41;
        tick();
        host.in_valid = 1'b0;
        exp = {1'b0, 8'h00, 3'd1, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL latency_n got=%h want=%h", obs, exp);
        end
        tick();
        exp = {1'b1, 8'h41, 3'd0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL latency_n1 got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            host.in_valid = 1'b1;
            host.in_data  = 8'(8'h41 + i);
            tick();
        end
        host.in_valid = 1'b0;
        exp = {1'b1, 8'h41, 3'd2, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL b2b_loaded got=%h want=%h", obs, exp);
        end
        for (int i = 0; i < 3; i++) begin
            inp_ack = 1'b1;
            tick();
            inp_ack = 1'b0;
            if (i < 2) exp = {1'b1, 8'(8'h42 + i), 3'(1 - i), 1'b1, 1'b0};
            else       exp = {1'b0, 8'h43, 3'd0, 1'b1, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL b2b_ack%0d got=%h want=%h", i, obs, exp);
            end
            tick();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL b2b_hold%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_fill();
        logic [13:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            host.in_valid = 1'b1;
            host.in_data  = 8'(8'h10 + i);
            tick();
        end
        host.in_data = 8'h15;
        tick();
        exp = {1'b1, 8'h10, 3'd4, 1'b0, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL fill_full got=%h want=%h", obs, exp);
        end
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        exp = {1'b1, 8'h11, 3'd3, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL fill_ack got=%h want=%h", obs, exp);
        end
        tick();
        host.in_valid = 1'b0;
        exp = {1'b1, 8'h11, 3'd4, 1'b0, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL fill_sixth got=%h want=%h", obs, exp);
        end
        inp_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = {1'b1, 8'(8'h12 + i), 3'(3 - i), 1'b1, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL fill_drain%0d got=%h want=%h", i, obs, exp);
            end
        end
        tick();
        inp_ack = 1'b0;
        exp = {1'b0, 8'h15, 3'd0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL fill_empty got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] exp;
        logic [7:0]  base;
        for (int r = 0; r < 3; r++) begin
            base = 8'(8'h20 + r * 16);
            for (int i = 0; i < 5; i++) begin
                host.in_valid = 1'b1;
                host.in_data  = 8'(base + i);
                tick();
            end
            host.in_valid = 1'b0;
            exp = {1'b1, base, 3'd4, 1'b0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL wrap%0d_full got=%h want=%h", r, obs, exp);
            end
            inp_ack = 1'b1;
            for (int i = 1; i < 5; i++) begin
                tick();
                exp = {1'b1, 8'(base + i), 3'(4 - i), 1'b1, 1'b0};
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL wrap%0d_pop%0d got=%h want=%h", r, i, obs, exp);
                end
            end
            tick();
            inp_ack = 1'b0;
            exp = {1'b0, 8'(base + 4), 3'd0, 1'b1, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL wrap%0d_empty got=%h want=%h", r, obs, exp);
            end
        end
    endtask

    task automatic test_ack_err_reset();
        logic [13:0] exp;
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        exp = {1'b0, 8'h44, 3'd0, 1'b1, 1'b1};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL ack_err_set got=%h want=%h", obs, exp);
        end
        tick();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL ack_err_sticky got=%h want=%h", obs, exp);
        end
        for (int i = 0; i < 4; i++) begin
            host.in_valid = 1'b1;
            host.in_data  = 8'(8'h60 + i);
            tick();
        end
        exp = {1'b1, 8'h60, 3'd3, 1'b1, 1'b1};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midfill_state got=%h want=%h", obs, exp);
        end
        rst_n        = 1'b0;
        host.in_data = 8'h64;
        tick();
        exp = {1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midfill_reset got=%h want=%h", obs, exp);
        end
        rst_n        = 1'b1;
        host.in_data = 8'h55;
        tick();
        host.in_valid = 1'b0;
        exp = {1'b0, 8'h00, 3'd1, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL post_reset_push got=%h want=%h", obs, exp);
        end
        tick();
        exp = {1'b1, 8'h55, 3'd0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL post_reset_load got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_flush();
        logic [13:0] exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            host.in_valid = 1'b1;
            host.in_data  = 8'(8'h70 + i);
            tick();
        end
        host.in_valid = 1'b0;
        exp = {1'b1, 8'h70, 3'd2, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL flush_pre got=%h want=%h", obs, exp);
        end
        flush         = 1'b1;
        inp_ack       = 1'b1;
        host.in_valid = 1'b1;
        host.in_data  = 8'h99;
        tick();
        flush         = 1'b0;
        inp_ack       = 1'b0;
        host.in_valid = 1'b0;
        exp = {1'b0, 8'h70, 3'd0, 1'b1, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL flush_edge got=%h want=%h", obs, exp);
        end
        tick();
        tick();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL flush_dropped got=%h want=%h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_fill();
        test_wrap();
        test_ack_err_reset();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bc_input_port.md
Name: bc_input_port

Overview:
- Upstream input-device interface for the Basic Computer. Feeds the FGI flag and the 8-bit INPR character register.
- Accepts characters from a host/testbench byte stream over a valid/ready handshake and buffers them in a small FIFO.
- Presents one character at a time in INPR with FGI=1.
- Releases the character when the controller signals execution of INP (inp_ack), then loads the next character.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- DATA_W, 8, character width (INPR width).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  host has a character on in_data.
- in_data  input  DATA_W  host character.
- in_ready  output  1  block can accept a character this cycle.
- inp_ack  input  1  one-cycle pulse from controller: INP executed, INPR consumed, clear FGI.
- flush  input  1  discard FIFO contents and any pending INPR character.
- FGI  output  1  input flag: INPR holds an unconsumed character.
- INPR  output  DATA_W  input character register.
- fifo_count  output  $clog2(DEPTH)+1  number of characters in FIFO (excludes INPR).
- ack_err  output  1  sticky: inp_ack seen while FGI=0.

Behaviour:
- Reset (rst_n=0 at an edge): FIFO pointers=0, fifo_count=0, FGI=0, INPR=0, ack_err=0. in_ready reads 1 in the first cycle after reset.
- Reset asserted mid-transfer: all state is discarded. A beat presented with in_valid=1 during reset is not accepted.
- Handshake:
  - A beat is accepted on an edge where in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH); it is a registered-state function only, with no combinational path from in_valid or inp_ack.
  - When full, in_ready=0 even if a pop occurs in the same cycle. No bypass.
- FIFO: circular buffer with wrap-around pointers. Simultaneous push and pop (when not full) leaves fifo_count unchanged.
- INPR load (pop):
  - Occurs on an edge where fifo_count>0 and (FGI==0 or inp_ack==1).
  - On that edge: INPR <= head, FGI <= 1, read pointer advances.
- FGI clear: on an edge with inp_ack=1, FGI=1 and fifo_count==0, FGI <= 0. INPR retains its last value.
- Back-to-back: inp_ack with FIFO non-empty reloads INPR on the same edge and FGI stays 1 continuously.
- Latency:
  - A character accepted at edge N into an empty FIFO with FGI=0 appears in INPR with FGI=1 after edge N+1.
  - fifo_count shows 1 between edges N and N+1.
- inp_ack with FGI=0: no data change, and ack_err <= 1. ack_err clears only on reset.
- flush:
  - On the edge: FIFO emptied, FGI <= 0, INPR unchanged.
  - flush has priority over a simultaneous push, pop and inp_ack; the concurrent input beat is dropped, but in_ready still reflects pre-flush state.
- Priority per edge: reset > flush > (push, pop, FGI update evaluated together).
- All outputs are registered except in_ready, which is decoded from fifo_count.

Test Plan:
- Reset then idle → FGI=0, INPR=0x00, fifo_count=0, in_ready=1, ack_err=0.
- Push 0x41 at edge N, no ack → fifo_count=1 after N, then FGI=1, INPR=0x41, fifo_count=0 after N+1.
- Push 0x41,0x42,0x43 in consecutive cycles, then pulse inp_ack three times, one cycle apart:
  - INPR 0x41→0x42→0x43 with FGI held 1.
  - After the third ack, FGI=0 and INPR stays 0x43.
- Fill: push 5 characters with no ack (DEPTH=4):
  - First goes to INPR; next 4 fill the FIFO, giving fifo_count=4 and in_ready=0.
  - The 6th beat is held off; one inp_ack → INPR=2nd char, fifo_count=3, in_ready=1 next cycle.
  - Pointers wrap correctly over 3 fill/drain rounds, with a data-order scoreboard.
- inp_ack while FGI=0 → ack_err=1 and sticky. Reset mid-fill with fifo_count=3 → all outputs at reset values; a subsequent push of 0x55 appears in INPR after 2 edges.
- flush with FGI=1, fifo_count=2 and a concurrent push of 0x99 → FGI=0, fifo_count=0, 0x99 not delivered, INPR unchanged.
